// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer driving a return-address stack (jump/call/return)
module pc_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              jmp,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] stk_out,
  output logic [ADDR_W-1:0] pc,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [ADDR_W-1:0] stk_in,
  output logic              busy,
  output logic              ovf,
  output logic              unf
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);
  typedef enum logic [1:0] {RUN, PUSH, POP} state_t;
  state_t state;
  logic [DW-1:0] depth;
  logic [ADDR_W-1:0] pc_inc;
  assign pc_inc = pc + ADDR_W'(1);
  // Strobes decode straight from state so an async reset drops them at once
  assign stk_push = state == PUSH;
  assign stk_pop  = state == POP;
  assign busy     = state != RUN;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      pc     <= '0;
      stk_in <= '0;
      depth  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (state == PUSH) begin
      state <= RUN;
    end else if (state == POP) begin
      pc    <= stk_out;
      state <= RUN;
    end else if (en) begin
      if (ret) begin
        if (depth != '0) begin
          depth <= depth - DW'(1);
          state <= POP;
        end else begin
          unf <= 1'b1;
          pc  <= pc_inc;
        end
      end else if (call) begin
        if (depth != FULL) begin
          stk_in <= pc_inc;
          pc     <= target;
          depth  <= depth + DW'(1);
          state  <= PUSH;
        end else begin
          ovf <= 1'b1;
          pc  <= pc_inc;
        end
      end else begin
        pc <= jmp ? target : pc_inc;
      end
    end
  end
endmodule
